proc_datapath: RTL and testbench

Datapath and step sequencer for the 8-register LAOC2 processor, sitting directly downstream of `Unidade_Controle`. It holds the instruction register, the step counter, R0–R7, the A and G registers, the ALU and the shared bus. It consumes the control unit's enables each cycle and feeds back `Counter`, `IRout`, `Xreg` and `Yreg`, closing the fetch/execute loop.

---
 rtl/proc_pkg.sv | 21 ++
 rtl/proc_alu.sv | 28 ++
 rtl/proc_datapath.sv | 94 +++++++++
 tb/tb_proc_datapath.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared constants for the LAOC2 datapath
package proc_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_IRW   = 10;

    localparam logic [3:0] ADD = 4'b0000;
    localparam logic [3:0] SUB = 4'b0001;
    localparam logic [3:0] SLT = 4'b0010;
    localparam logic [3:0] SLL = 4'b0011;
    localparam logic [3:0] SLR = 4'b0100;
    localparam logic [3:0] AND = 4'b0101;
    localparam logic [3:0] MV  = 4'b0110;
    localparam logic [3:0] MVI = 4'b1000;

    localparam logic [2:0] S0 = 3'd0;
    localparam logic [2:0] S1 = 3'd1;
    localparam logic [2:0] S2 = 3'd2;
    localparam logic [2:0] S3 = 3'd3;

endpackage

// File: rtl/proc_alu.sv
// rtl/proc_alu.sv - combinational ALU, function selected by the IR opcode
module proc_alu
    import proc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result
);

    logic lt;
    assign lt = $signed(a) < $signed(b);

    always_comb begin
        result = a + b;
        case (opcode)
            SUB:     result = a - b;
            SLT:     result = {{(WIDTH-1){1'b0}}, lt};
            SLL:     result = a << b[3:0];
            SLR:     result = a >> b[3:0];
            AND:     result = a & b;
            default: result = a + b;
        endcase
    end

endmodule

// File: rtl/proc_datapath.sv
// rtl/proc_datapath.sv - LAOC2 datapath: IR, step counter, R0-R7, A, G and shared bus
module proc_datapath
    import proc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IRW   = DEF_IRW
) (
    input  logic             clock,
    input  logic             Reset,
    input  logic             Run,
    input  logic [WIDTH-1:0] DIN,
    input  logic             IRin,
    input  logic             Ain,
    input  logic             Gin,
    input  logic             Gout,
    input  logic             DINout,
    input  logic [7:0]       Rin,
    input  logic [7:0]       Rout,
    input  logic             Done,
    output logic [2:0]       Counter,
    output logic [IRW-1:0]   IRout,
    output logic [7:0]       Xreg,
    output logic [7:0]       Yreg,
    output logic [WIDTH-1:0] BusWires,
    output logic [WIDTH-1:0] Gval
);

    logic [IRW-1:0]   ir;
    logic [WIDTH-1:0] r [8];
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] g_reg;
    logic [WIDTH-1:0] alu_result;
    logic [2:0]       step;

    // Scanning downward lets the lowest set Rout bit win.
    always_comb begin
        BusWires = '0;
        if (DINout) begin
            BusWires = DIN;
        end else if (Gout) begin
            BusWires = g_reg;
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (Rout[i]) BusWires = r[i];
            end
        end
    end

    proc_alu #(.WIDTH(WIDTH)) u_alu (
        .opcode (ir[IRW-1 -: 4]),
        .a      (a_reg),
        .b      (BusWires),
        .result (alu_result)
    );

    always_ff @(posedge clock) begin
        if (Reset) begin
            ir    <= '0;
            a_reg <= '0;
            g_reg <= '0;
            for (int i = 0; i < 8; i++) r[i] <= '0;
        end else begin
            if (IRin) ir    <= DIN[IRW-1:0];
            if (Ain)  a_reg <= BusWires;
            if (Gin)  g_reg <= alu_result;
            for (int i = 0; i < 8; i++) begin
                if (Rin[i]) r[i] <= BusWires;
            end
        end
    end

    // S3 always falls back to S0 so an undefined opcode cannot stall the core.
    always_ff @(posedge clock) begin
        if (Reset) begin
            step <= S0;
        end else if (Done) begin
            step <= S0;
        end else begin
            case (step)
                S0:      step <= Run ? S1 : S0;
                S1:      step <= S2;
                S2:      step <= S3;
                default: step <= S0;
            endcase
        end
    end

    assign Counter = step;
    assign IRout   = ir;
    assign Gval    = g_reg;
    assign Xreg    = 8'b1 << ir[5:3];
    assign Yreg    = 8'b1 << ir[2:0];

endmodule

// File: tb/tb_proc_datapath.sv
// tb/tb_proc_datapath.sv - directed self-checking bench for proc_datapath
module tb_proc_datapath;
    import proc_pkg::*;

    logic        clock;
    logic        Reset;
    logic        Run;
    logic [15:0] DIN;
    logic        IRin, Ain, Gin, Gout, DINout, Done;
    logic [7:0]  Rin, Rout;
    logic [2:0]  Counter;
    logic [9:0]  IRout;
    logic [7:0]  Xreg, Yreg;
    logic [15:0] BusWires, Gval;

    int n_checks = 0;
    int n_fail   = 0;

    proc_datapath #(.WIDTH(16), .IRW(10)) dut (
        .clock    (clock),
        .Reset    (Reset),
        .Run      (Run),
        .DIN      (DIN),
        .IRin     (IRin),
        .Ain      (Ain),
        .Gin      (Gin),
        .Gout     (Gout),
        .DINout   (DINout),
        .Rin      (Rin),
        .Rout     (Rout),
        .Done     (Done),
        .Counter  (Counter),
        .IRout    (IRout),
        .Xreg     (Xreg),
        .Yreg     (Yreg),
        .BusWires (BusWires),
        .Gval     (Gval)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_ctl;
        Run = 0; IRin = 0; Ain = 0; Gin = 0; Gout = 0; DINout = 0;
        Rin = 8'h00; Rout = 8'h00; Done = 0;
    endtask

    task automatic read_reg(input string tag, input int idx, input logic [15:0] exp);
        clear_ctl();
        Rout = 8'(1 << idx);
        #1;
        check_eq(tag, 32'(BusWires), 32'(exp));
        Rout = 8'h00;
    endtask

    task automatic do_mvi(input int idx, input logic [15:0] val);
        clear_ctl();
        IRin = 1; Run = 1; DIN = {6'b0, MVI, 3'(idx), 3'b000};
        cyc();
        clear_ctl();
        DINout = 1; DIN = val; Rin = 8'(1 << idx); Done = 1;
        cyc();
        clear_ctl();
    endtask

    task automatic do_alu(input string tag, input logic [3:0] op, input int x, input int y);
        clear_ctl();
        IRin = 1; Run = 1; DIN = {6'b0, op, 3'(x), 3'(y)};
        cyc();
        check_eq({tag, "_s1"}, 32'(Counter), 32'd1);
        clear_ctl();
        Rout = 8'(1 << x); Ain = 1;
        cyc();
        clear_ctl();
        Rout = 8'(1 << y); Gin = 1;
        cyc();
        check_eq({tag, "_s3"}, 32'(Counter), 32'd3);
        clear_ctl();
        Gout = 1; Rin = 8'(1 << x); Done = 1;
        cyc();
        check_eq({tag, "_s0"}, 32'(Counter), 32'd0);
        clear_ctl();
    endtask

    initial begin
        clear_ctl();
        DIN = 16'h0000;
        Reset = 1;
        cyc();
        cyc();
        Reset = 0;
        #1;
        check_eq("rst_counter", 32'(Counter), 32'd0);
        check_eq("rst_ir", 32'(IRout), 32'd0);
        check_eq("rst_xreg", 32'(Xreg), 32'h01);
        check_eq("rst_yreg", 32'(Yreg), 32'h01);
        check_eq("rst_g", 32'(Gval), 32'd0);
        check_eq("rst_bus", 32'(BusWires), 32'd0);
        read_reg("rst_r3", 3, 16'h0000);

        // mvi R1, #0x1234 with explicit step checks
        IRin = 1; Run = 1; DIN = 16'b0000_0010_0000_1000;
        cyc();
        check_eq("mvi_counter1", 32'(Counter), 32'd1);
        check_eq("mvi_ir", 32'(IRout), 32'h208);
        check_eq("mvi_xreg", 32'(Xreg), 32'h02);
        check_eq("mvi_yreg", 32'(Yreg), 32'h01);
        clear_ctl();
        DINout = 1; DIN = 16'h1234; Rin = 8'h02; Done = 1;
        #1;
        check_eq("mvi_bus", 32'(BusWires), 32'h1234);
        cyc();
        check_eq("mvi_counter0", 32'(Counter), 32'd0);
        read_reg("mvi_r1", 1, 16'h1234);

        // 5 - 7 = -2
        do_mvi(1, 16'd5);
        do_mvi(2, 16'd7);
        do_alu("sub", SUB, 1, 2);
        check_eq("sub_g", 32'(Gval), 32'hFFFE);
        read_reg("sub_r1", 1, 16'hFFFE);
        read_reg("sub_r2", 2, 16'd7);

        do_mvi(1, 16'd5);
        do_alu("slt", SLT, 1, 2);
        read_reg("slt_r1", 1, 16'd1);

        // -2 < -3 is false in signed compare
        do_mvi(1, 16'hFFFE);
        do_mvi(2, 16'hFFFD);
        do_alu("slt_neg", SLT, 1, 2);
        read_reg("slt_neg_r1", 1, 16'd0);

        do_mvi(1, 16'd5);
        do_mvi(2, 16'd4);
        do_alu("sll", SLL, 1, 2);
        read_reg("sll_r1", 1, 16'h0050);

        do_alu("slr", SLR, 1, 2);
        read_reg("slr_r1", 1, 16'h0005);

        do_alu("and", AND, 1, 2);
        read_reg("and_r1", 1, 16'h0004);
        check_eq("and_g", 32'(Gval), 32'h0004);

        // opcode 1100 falls back to add: 4 + 4
        do_alu("dflt", 4'b1100, 1, 2);
        read_reg("dflt_r1", 1, 16'h0008);

        // bus priority
        do_mvi(0, 16'hAAAA);
        do_mvi(7, 16'h7777);
        clear_ctl();
        DIN = 16'hBEEF; DINout = 1; Gout = 1; Rout = 8'h81;
        #1;
        check_eq("bus_din", 32'(BusWires), 32'hBEEF);
        DINout = 0;
        #1;
        check_eq("bus_g", 32'(BusWires), 32'h0008);
        Gout = 0;
        #1;
        check_eq("bus_r0", 32'(BusWires), 32'hAAAA);
        Rout = 8'h80;
        #1;
        check_eq("bus_r7", 32'(BusWires), 32'h7777);
        Rout = 8'h00;
        #1;
        check_eq("bus_none", 32'(BusWires), 32'h0000);

        // undefined opcode without Done recovers through S3
        clear_ctl();
        IRin = 1; Run = 1; DIN = {6'b0, 4'b1111, 3'd1, 3'd2};
        cyc();
        check_eq("undef_c1", 32'(Counter), 32'd1);
        clear_ctl();
        cyc();
        check_eq("undef_c2", 32'(Counter), 32'd2);
        cyc();
        check_eq("undef_c3", 32'(Counter), 32'd3);
        cyc();
        check_eq("undef_c0", 32'(Counter), 32'd0);
        read_reg("undef_r1", 1, 16'h0008);
        check_eq("undef_g", 32'(Gval), 32'h0008);

        // Run low: counter holds, IR tracks DIN
        for (int i = 0; i < 5; i++) begin
            clear_ctl();
            IRin = 1;
            DIN = 16'hF000 | 16'(i * 16'h0053);
            cyc();
            check_eq($sformatf("hold_c%0d", i), 32'(Counter), 32'd0);
            check_eq($sformatf("hold_ir%0d", i), 32'(IRout), 32'(10'(16'h0000 | (i * 16'h0053))));
        end

        // Reset in S2 overrides Rin/Gin
        clear_ctl();
        IRin = 1; Run = 1; DIN = {6'b0, ADD, 3'd2, 3'd1};
        cyc();
        clear_ctl();
        cyc();
        check_eq("rst2_pre", 32'(Counter), 32'd2);
        Reset = 1; Rin = 8'h04; Gin = 1; DINout = 1; DIN = 16'h1234;
        cyc();
        Reset = 0;
        clear_ctl();
        #1;
        check_eq("rst2_counter", 32'(Counter), 32'd0);
        check_eq("rst2_g", 32'(Gval), 32'd0);
        check_eq("rst2_bus", 32'(BusWires), 32'd0);
        check_eq("rst2_ir", 32'(IRout), 32'd0);
        read_reg("rst2_r2", 2, 16'h0000);
        read_reg("rst2_r0", 0, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
